probe_conditioner: RTL and testbench

Input conditioning stage directly upstream of the correlator's `i_x`/`i_y` probes. It synchronises two asynchronous pin inputs and optionally inverts them. It converts them to level or edge events and pulse-stretches each event so narrow activity is not missed by the correlator's strobed sampling. It also keeps saturating per-channel event counts for host sanity checks.

---
 rtl/probe_conditioner_pkg.sv | 38 +++
 rtl/probe_conditioner_chan.sv | 69 ++++++
 rtl/probe_conditioner.sv | 59 +++++
 tb/tb_probe_conditioner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_conditioner_pkg.sv
// Shared definitions for the correlator probe conditioner: event-mode encodings
// and the mode-dependent event rule used by both probe channels.
package probe_conditioner_pkg;

    localparam int unsigned PROBEMODE_W = 2;

    localparam logic [PROBEMODE_W-1:0] PROBEMODE_LEVEL = 2'd0;
    localparam logic [PROBEMODE_W-1:0] PROBEMODE_RISE  = 2'd1;
    localparam logic [PROBEMODE_W-1:0] PROBEMODE_FALL  = 2'd2;
    localparam logic [PROBEMODE_W-1:0] PROBEMODE_ANY   = 2'd3;

    // Event for the current cycle given the conditioned level and its previous value.
    function automatic logic modeEvent(
        input logic [PROBEMODE_W-1:0] mode,
        input logic                   sVal,
        input logic                   prevVal
    );
        logic ev;
        case (mode)
            PROBEMODE_LEVEL: ev = sVal;
            PROBEMODE_RISE:  ev = sVal & ~prevVal;
            PROBEMODE_FALL:  ev = ~sVal & prevVal;
            default:         ev = sVal ^ prevVal;
        endcase
        return ev;
    endfunction

    // Counter increment: LEVEL counts high periods, edge modes count every event.
    function automatic logic modeCountInc(
        input logic [PROBEMODE_W-1:0] mode,
        input logic                   sVal,
        input logic                   prevVal,
        input logic                   ev
    );
        return (mode == PROBEMODE_LEVEL) ? (sVal & ~prevVal) : ev;
    endfunction

endpackage

// File: rtl/probe_conditioner_chan.sv
// One probe channel: pin synchroniser, optional inversion, event detection,
// retriggerable pulse stretcher and a saturating event counter.
module probe_conditioner_chan
    import probe_conditioner_pkg::*;
#(
    parameter int unsigned N_SYNC    = 2,
    parameter int unsigned STRETCH_W = 8,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic                   i_pin,
    input  logic                   i_invert,
    input  logic [PROBEMODE_W-1:0] i_mode,
    input  logic [STRETCH_W-1:0]   i_stretchM1,
    input  logic                   i_clearCount,
    output logic                   o_probe,
    output logic [COUNT_W-1:0]     o_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [N_SYNC-1:0]    syncQ;
    logic                 prevQ;
    logic [STRETCH_W-1:0] stretchQ;

    logic sVal_c;
    logic ev_c;
    logic countInc_c;
    logic stretchActive_c;

    // Conditioned level and this cycle's event decisions.
    always_comb begin
        sVal_c          = syncQ[N_SYNC-1] ^ i_invert;
        ev_c            = modeEvent(i_mode, sVal_c, prevQ);
        countInc_c      = modeCountInc(i_mode, sVal_c, prevQ, ev_c);
        stretchActive_c = (stretchQ != '0);
    end

    // All channel state; the clock enable freezes the synchroniser as well.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            syncQ    <= '0;
            prevQ    <= 1'b0;
            stretchQ <= '0;
            o_probe  <= 1'b0;
            o_count  <= '0;
        end else if (i_cg) begin
            syncQ <= {syncQ[N_SYNC-2:0], i_pin};
            prevQ <= sVal_c;

            if (ev_c) begin
                stretchQ <= i_stretchM1;
            end else if (stretchActive_c) begin
                stretchQ <= stretchQ - STRETCH_W'(1);
            end

            o_probe <= ev_c | stretchActive_c;

            if (i_clearCount) begin
                o_count <= '0;
            end else if (countInc_c && (o_count != COUNT_MAX)) begin
                o_count <= o_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/probe_conditioner.sv
// Conditions the two asynchronous correlator probe pins; one identical channel
// per pin sharing mode, stretch and clear controls.
module probe_conditioner
    import probe_conditioner_pkg::*;
#(
    parameter int unsigned N_SYNC    = 2,
    parameter int unsigned STRETCH_W = 8,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic                   i_x,
    input  logic                   i_y,
    input  logic [1:0]             i_ctrl_invert,
    input  logic [PROBEMODE_W-1:0] i_ctrl_mode,
    input  logic [STRETCH_W-1:0]   i_ctrl_stretchM1,
    input  logic                   i_clearCounts,
    output logic                   o_x,
    output logic                   o_y,
    output logic [COUNT_W-1:0]     o_countX,
    output logic [COUNT_W-1:0]     o_countY
);

    probe_conditioner_chan #(
        .N_SYNC    (N_SYNC),
        .STRETCH_W (STRETCH_W),
        .COUNT_W   (COUNT_W)
    ) xChan (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cg         (i_cg),
        .i_pin        (i_x),
        .i_invert     (i_ctrl_invert[0]),
        .i_mode       (i_ctrl_mode),
        .i_stretchM1  (i_ctrl_stretchM1),
        .i_clearCount (i_clearCounts),
        .o_probe      (o_x),
        .o_count      (o_countX)
    );

    probe_conditioner_chan #(
        .N_SYNC    (N_SYNC),
        .STRETCH_W (STRETCH_W),
        .COUNT_W   (COUNT_W)
    ) yChan (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cg         (i_cg),
        .i_pin        (i_y),
        .i_invert     (i_ctrl_invert[1]),
        .i_mode       (i_ctrl_mode),
        .i_stretchM1  (i_ctrl_stretchM1),
        .i_clearCount (i_clearCounts),
        .o_probe      (o_y),
        .o_count      (o_countY)
    );

endmodule

// File: tb/tb_probe_conditioner.sv
// Bench for probe_conditioner: directed scenarios plus random stimulus, all
// cycles compared against a history-based reference model.
module tb_probe_conditioner;
    import probe_conditioner_pkg::*;

    localparam int N_SYNC    = 2;
    localparam int STRETCH_W = 8;
    localparam int COUNT_W   = 4;
    localparam int CNT_MAX   = (1 << COUNT_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_cg = 1'b1;
    logic                 i_x = 1'b0;
    logic                 i_y = 1'b0;
    logic [1:0]           i_ctrl_invert = 2'b00;
    logic [1:0]           i_ctrl_mode = PROBEMODE_LEVEL;
    logic [STRETCH_W-1:0] i_ctrl_stretchM1 = '0;
    logic                 i_clearCounts = 1'b0;
    logic                 o_x;
    logic                 o_y;
    logic [COUNT_W-1:0]   o_countX;
    logic [COUNT_W-1:0]   o_countY;

    int passCount  = 0;
    int checkCount = 0;

    probe_conditioner #(
        .N_SYNC    (N_SYNC),
        .STRETCH_W (STRETCH_W),
        .COUNT_W   (COUNT_W)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cg             (i_cg),
        .i_x              (i_x),
        .i_y              (i_y),
        .i_ctrl_invert    (i_ctrl_invert),
        .i_ctrl_mode      (i_ctrl_mode),
        .i_ctrl_stretchM1 (i_ctrl_stretchM1),
        .i_clearCounts    (i_clearCounts),
        .o_x              (o_x),
        .o_y              (o_y),
        .o_countX         (o_countX),
        .o_countY         (o_countY)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: pin history per enabled edge, time since last event, event tallies.
    bit histX[$];
    bit histY[$];
    bit lastS[2];
    int loadedLen[2];
    int sinceEv[2];
    bit expO[2];
    int expCnt[2];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        else passCount++;
    endtask

    function automatic bit pinDelayed(input int ch);
        if (ch == 0) return (histX.size() >= N_SYNC) ? histX[histX.size() - N_SYNC] : 1'b0;
        return (histY.size() >= N_SYNC) ? histY[histY.size() - N_SYNC] : 1'b0;
    endfunction

    task automatic modelEdge();
        bit s, ev, inc;
        bit inv[2];
        inv[0] = i_ctrl_invert[0];
        inv[1] = i_ctrl_invert[1];
        if (i_rst) begin
            histX.delete();
            histY.delete();
            for (int ch = 0; ch < 2; ch++) begin
                lastS[ch] = 1'b0; loadedLen[ch] = 0; sinceEv[ch] = 0;
                expO[ch] = 1'b0; expCnt[ch] = 0;
            end
        end else if (i_cg) begin
            for (int ch = 0; ch < 2; ch++) begin
                s = pinDelayed(ch) ^ inv[ch];
                case (i_ctrl_mode)
                    PROBEMODE_LEVEL: ev = s;
                    PROBEMODE_RISE:  ev = s && !lastS[ch];
                    PROBEMODE_FALL:  ev = !s && lastS[ch];
                    default:         ev = (s != lastS[ch]);
                endcase
                inc = (i_ctrl_mode == PROBEMODE_LEVEL) ? (s && !lastS[ch]) : ev;
                // Output stays up while fewer cycles than the loaded length have elapsed.
                expO[ch] = ev || (sinceEv[ch] < loadedLen[ch]);
                if (ev) begin
                    loadedLen[ch] = int'(i_ctrl_stretchM1);
                    sinceEv[ch]   = 0;
                end else if (sinceEv[ch] < loadedLen[ch]) begin
                    sinceEv[ch]++;
                end
                if (i_clearCounts) expCnt[ch] = 0;
                else if (inc && expCnt[ch] < CNT_MAX) expCnt[ch]++;
                lastS[ch] = s;
            end
            histX.push_back(i_x);
            histY.push_back(i_y);
            if (histX.size() > 16) void'(histX.pop_front());
            if (histY.size() > 16) void'(histY.pop_front());
        end
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge i_clk);
        modelEdge();
        @(negedge i_clk);
        checkEq("oX", 32'(o_x), 32'(expO[0]));
        checkEq("oY", 32'(o_y), 32'(expO[1]));
        checkEq("countX", 32'(o_countX), 32'(expCnt[0]));
        checkEq("countY", 32'(o_countY), 32'(expCnt[1]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    int hi;

    initial begin
        @(negedge i_clk);
        ticks(2);
        checkEq("rstOX", 32'(o_x), 32'd0);
        checkEq("rstCountY", 32'(o_countY), 32'd0);
        i_rst = 1'b0;

        // LEVEL, no stretch: delayed copy of the pin
        i_ctrl_mode = PROBEMODE_LEVEL;
        ticks(3);
        i_x = 1'b1;
        ticks(2);
        checkEq("lvlEarly", 32'(o_x), 32'd0);
        tick();
        checkEq("lvlRise", 32'(o_x), 32'd1);
        checkEq("lvlCount", 32'(o_countX), 32'd1);
        ticks(5);
        i_x = 1'b0;
        ticks(2);
        checkEq("lvlHold", 32'(o_x), 32'd1);
        tick();
        checkEq("lvlFall", 32'(o_x), 32'd0);
        checkEq("lvlCountEnd", 32'(o_countX), 32'd1);

        // RISE with stretch 3: single edge then two edges two cycles apart
        doReset();
        i_ctrl_mode = PROBEMODE_RISE;
        i_ctrl_stretchM1 = 8'd3;
        ticks(3);
        i_x = 1'b1;
        hi = 0;
        for (int i = 0; i < 12; i++) begin tick(); hi += int'(o_x); end
        checkEq("riseWidth", 32'(hi), 32'd4);
        hi = 0;
        i_x = 1'b0; tick(); hi += int'(o_x);
        i_x = 1'b1; tick(); hi += int'(o_x);
        i_x = 1'b0; tick(); hi += int'(o_x);
        i_x = 1'b1;
        for (int i = 0; i < 12; i++) begin tick(); hi += int'(o_x); end
        checkEq("retrigWidth", 32'(hi), 32'd6);
        checkEq("retrigCount", 32'(o_countX), 32'd3);

        // FALL then ANY on inverted y
        i_x = 1'b0;
        i_ctrl_stretchM1 = 8'd0;
        i_ctrl_invert = 2'b10;
        i_ctrl_mode = PROBEMODE_FALL;
        doReset();
        ticks(4);
        hi = 0;
        i_y = 1'b1; tick(); hi += int'(o_y);
        i_y = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); hi += int'(o_y); end
        checkEq("fallEvents", 32'(hi), 32'd1);
        checkEq("fallCountY", 32'(o_countY), 32'd1);
        i_ctrl_mode = PROBEMODE_ANY;
        hi = 0;
        i_y = 1'b1; tick(); hi += int'(o_y);
        i_y = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); hi += int'(o_y); end
        checkEq("anyEvents", 32'(hi), 32'd2);
        checkEq("anyCountY", 32'(o_countY), 32'd3);

        // Saturation and clear coincident with events
        i_ctrl_invert = 2'b00;
        doReset();
        ticks(3);
        for (int i = 0; i < 20; i++) begin i_y = ~i_y; tick(); end
        ticks(3);
        checkEq("satCountY", 32'(o_countY), 32'(CNT_MAX));
        i_clearCounts = 1'b1;
        for (int i = 0; i < 3; i++) begin i_y = ~i_y; tick(); end
        checkEq("clearWins", 32'(o_countY), 32'd0);
        i_clearCounts = 1'b0;
        ticks(4);

        // Clock enable low in the middle of a stretch
        i_ctrl_mode = PROBEMODE_RISE;
        i_ctrl_stretchM1 = 8'd10;
        i_y = 1'b0;
        doReset();
        ticks(3);
        i_x = 1'b1;
        ticks(4);
        i_cg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkEq("cgHoldO", 32'(o_x), 32'd1);
        end
        checkEq("cgHoldCount", 32'(o_countX), 32'd1);
        i_cg = 1'b1;
        hi = 0;
        for (int i = 0; i < 15; i++) begin tick(); hi += int'(o_x); end
        checkEq("cgResume", 32'(hi), 32'd9);

        // Reset mid-stretch with x held high
        i_x = 1'b0;
        doReset();
        ticks(3);
        i_x = 1'b1;
        ticks(4);
        i_rst = 1'b1;
        tick();
        checkEq("rstMidO", 32'(o_x), 32'd0);
        checkEq("rstMidCount", 32'(o_countX), 32'd0);
        i_rst = 1'b0;
        ticks(20);
        checkEq("rstOneEvent", 32'(o_countX), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_x = 1'($urandom_range(0, 1));
            i_y = ($urandom_range(0, 3) == 0) ? ~i_y : i_y;
            i_cg = ($urandom_range(0, 9) != 0);
            i_rst = ($urandom_range(0, 199) == 0);
            i_clearCounts = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 31) == 0) i_ctrl_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) i_ctrl_invert = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) i_ctrl_stretchM1 = 8'($urandom_range(0, 6));
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
